memory_refresh_scheduler: RTL and testbench
===========================================

// Module: memory_refresh_scheduler
// PURPOSE
//  Shares the memory macro between system read/write requests and periodic row refresh.
//  Consumes a 1-cycle refresh tick (derived from the refresh clock divider) and counts owed refreshes.
//  Issues one memory operation at a time. System accesses win unless the refresh backlog is urgent.
//  Sits between the clock divider/request logic and the memory array's control pins.
// PARAMETERS
//  AW         9    memory address width (bits)
//  ROWS       64   rows to refresh; refresh row counter wraps ROWS-1 -> 0
//  ACC_CYC    2    cycles mem_cs is held per system access (>=1)
//  REF_CYC    3    cycles mem_ref is held per row refresh (>=1)
//  MAX_PEND   4    backlog depth; pend_cnt==MAX_PEND makes refresh urgent
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  reset        in   1              asynchronous, active-high; clears all state
//  enabled      in   1              0: no new operation starts; in-flight op completes; ticks still counted
//  refresh_tick in   1              1-cycle pulse: one row refresh owed
//  req_valid    in   1              system request present; held with fields stable until req_ready
//  req_we       in   1              1=write, 0=read
//  req_addr     in   AW             system address
//  req_ready    out  1              1-cycle grant pulse; request accepted on valid&ready
//  req_done     out  1              1-cycle pulse in the last mem_cs cycle of an access
//  mem_cs       out  1              memory select for system access
//  mem_we       out  1              write strobe, valid with mem_cs
//  mem_ref      out  1              refresh strobe
//  mem_addr     out  AW             access address, or zero-extended refresh row
//  pend_cnt     out  $clog2(MAX_PEND+1)  owed refreshes
//  ref_overrun  out  1              sticky: tick arrived while pend_cnt==MAX_PEND
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, row counter 0, cycle counter 0.
//  FSM states:
//   - IDLE: start an operation only if enabled=1.
//     Priority: urgent refresh (pend_cnt==MAX_PEND) > req_valid > pend_cnt>0 > stay.
//   - IDLE->ACC: req_ready=1 this cycle; latch we/addr. ACC drives mem_cs=1 for ACC_CYC cycles.
//     Latched address is on mem_addr from the first ACC cycle. Then IDLE.
//   - IDLE->REF: mem_ref=1, mem_addr=row for REF_CYC cycles. On the final cycle, row increments
//     (ROWS-1 wraps to 0) and pend_cnt decrements. Then IDLE.
//  Grant to first mem_cs: 1 cycle. Back-to-back accesses: one IDLE cycle between operations.
//  pend_cnt: +1 on tick, -1 on refresh completion. Simultaneous tick and completion: unchanged.
//   - Saturates at MAX_PEND. A tick at saturation without a same-cycle completion sets ref_overrun.
//   - ref_overrun clears only on reset.
//  Mutual exclusion: mem_cs, mem_ref and req_ready are never both 1 with each other.
//  mem_we=0 whenever mem_cs=0. mem_addr holds its last value while idle.
//  enabled dropping mid-operation does not abort the operation.
//  Reset mid-operation aborts it immediately; the next access restarts cleanly.
//  ACC_CYC/REF_CYC counters are $clog2(max+1) wide; no wrap beyond terminal count.
// STRUCTURE
//  Package mem_ctrl_pkg: FSM state enum {IDLE,ACC,REF}, default AW/ROWS constants.
//  Sub-module refresh_backlog_counter: pend_cnt saturation and ref_overrun logic.
//  FSM, cycle counter and row counter live in the top module.
// TESTING
//  1. Reset held, then released; no activity -> all outputs 0, pend_cnt 0.
//  2. Write request, addr 0x1A5, ACC_CYC=2 -> req_ready 1 cycle, then mem_cs=mem_we=1 addr 0x1A5 for 2 cycles;
//     req_done on the 2nd cycle.
//  3. One tick while idle -> mem_ref 3 cycles at row 0; pend_cnt 1->0; next tick refreshes row 1.
//     After 64 refreshes, row wraps to 0.
//  4. req_valid held high, 4 ticks -> access served until pend_cnt==4. Then refresh takes priority,
//     then access is granted again.
//  5. 5 ticks with enabled=0 -> pend_cnt=4, ref_overrun=1 (sticky). Tick coincident with refresh
//     completion -> pend_cnt unchanged.
//  6. Assert reset mid-ACC and mid-REF -> outputs 0 in the same cycle; after release, a normal access completes.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory refresh scheduler.
// Holds the FSM state encoding and counter-width helpers.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      REF  = 2'd2
   } state_t;

   localparam int DEF_AW       = 9;
   localparam int DEF_ROWS     = 64;
   localparam int DEF_ACC_CYC  = 2;
   localparam int DEF_REF_CYC  = 3;
   localparam int DEF_MAX_PEND = 4;

   function automatic int cnt_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

   function automatic int row_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/memory_refresh_scheduler_backlog.sv
// Owed-refresh counter: saturating at MAX_PEND, with a sticky
// overrun flag for ticks that arrive while the backlog is full.
module refresh_backlog_counter
   import mem_ctrl_pkg::*;
#(
   parameter int MAX_PEND = DEF_MAX_PEND,
   parameter int PW       = $clog2(MAX_PEND + 1)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_tick,
   input  logic          i_done,
   output logic [PW-1:0] o_pend_cnt,
   output logic          o_overrun
);

   logic [PW-1:0] r_pend;
   logic          r_overrun;
   logic          w_full;

   assign w_full = (r_pend == PW'(MAX_PEND));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pend    <= '0;
         r_overrun <= 1'b0;
      end else begin
         // tick and completion together cancel out
         unique case ({i_tick, i_done})
            2'b10: begin
               if (w_full) r_overrun <= 1'b1;
               else        r_pend    <= r_pend + PW'(1);
            end
            2'b01: begin
               if (r_pend != '0) r_pend <= r_pend - PW'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_pend_cnt = r_pend;
   assign o_overrun  = r_overrun;

endmodule

// File: rtl/memory_refresh_scheduler.sv
// Arbitrates the memory macro between system accesses and row refresh.
// One operation at a time; urgent refresh backlog beats system requests.
module memory_refresh_scheduler
   import mem_ctrl_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int ROWS     = DEF_ROWS,
   parameter int ACC_CYC  = DEF_ACC_CYC,
   parameter int REF_CYC  = DEF_REF_CYC,
   parameter int MAX_PEND = DEF_MAX_PEND,
   parameter int PW       = $clog2(MAX_PEND + 1)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_enabled,
   input  logic          i_refresh_tick,
   input  logic          i_req_valid,
   input  logic          i_req_we,
   input  logic [AW-1:0] i_req_addr,
   output logic          o_req_ready,
   output logic          o_req_done,
   output logic          o_mem_cs,
   output logic          o_mem_we,
   output logic          o_mem_ref,
   output logic [AW-1:0] o_mem_addr,
   output logic [PW-1:0] o_pend_cnt,
   output logic          o_ref_overrun
);

   localparam int CW = cnt_width(ACC_CYC, REF_CYC);
   localparam int RW = row_width(ROWS);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_row;
   logic [AW-1:0] r_addr;
   logic          r_we;
   logic [PW-1:0] w_pend;
   logic          w_urgent;
   logic          w_acc_last;
   logic          w_ref_last;
   logic          w_grant;
   logic          w_start_ref;

   refresh_backlog_counter #(
      .MAX_PEND (MAX_PEND),
      .PW       (PW)
   ) u_backlog (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_tick     (i_refresh_tick),
      .i_done     (w_ref_last),
      .o_pend_cnt (w_pend),
      .o_overrun  (o_ref_overrun)
   );

   assign w_urgent   = (w_pend == PW'(MAX_PEND));
   assign w_acc_last = (r_state == ACC) && (r_cnt == CW'(ACC_CYC - 1));
   assign w_ref_last = (r_state == REF) && (r_cnt == CW'(REF_CYC - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_grant     = 1'b0;
      w_start_ref = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_enabled) begin
               if (w_urgent) begin
                  w_start_ref = 1'b1;
                  w_next      = REF;
               end else if (i_req_valid) begin
                  w_grant = 1'b1;
                  w_next  = ACC;
               end else if (w_pend != '0) begin
                  w_start_ref = 1'b1;
                  w_next      = REF;
               end
            end
         end
         ACC: begin
            if (w_acc_last) w_next = IDLE;
         end
         REF: begin
            if (w_ref_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Address register doubles as the idle hold value of mem_addr
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt  <= '0;
         r_row  <= '0;
         r_addr <= '0;
         r_we   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_addr <= i_req_addr;
            r_we   <= i_req_we;
            r_cnt  <= '0;
         end else if (w_start_ref) begin
            r_addr <= AW'(r_row);
            r_cnt  <= '0;
         end else if (w_acc_last || w_ref_last) begin
            r_cnt <= '0;
         end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_ref_last) begin
            if (r_row == RW'(ROWS - 1)) r_row <= '0;
            else                        r_row <= r_row + RW'(1);
         end
      end
   end

   assign o_req_ready = w_grant;
   assign o_req_done  = w_acc_last;
   assign o_mem_cs    = (r_state == ACC);
   assign o_mem_we    = (r_state == ACC) && r_we;
   assign o_mem_ref   = (r_state == REF);
   assign o_mem_addr  = r_addr;
   assign o_pend_cnt  = w_pend;

endmodule

// File: tb/tb_memory_refresh_scheduler.sv
// Scoreboard bench: stimulus queues expected memory-side events,
// a negedge monitor pops and compares whenever the DUT acts.
module tb_memory_refresh_scheduler;
   import mem_ctrl_pkg::*;

   localparam int AW = 9;
   localparam int PW = 3;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          en    = 1'b0;
   logic          tick  = 1'b0;
   logic          valid = 1'b0;
   logic          we    = 1'b0;
   logic [AW-1:0] addr  = '0;
   logic          o_req_ready, o_req_done, o_mem_cs, o_mem_we, o_mem_ref;
   logic [AW-1:0] o_mem_addr;
   logic [PW-1:0] o_pend_cnt;
   logic          o_ref_overrun;

   memory_refresh_scheduler #(
      .AW(AW), .ROWS(64), .ACC_CYC(2), .REF_CYC(3), .MAX_PEND(4), .PW(PW)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_enabled      (en),
      .i_refresh_tick (tick),
      .i_req_valid    (valid),
      .i_req_we       (we),
      .i_req_addr     (addr),
      .o_req_ready    (o_req_ready),
      .o_req_done     (o_req_done),
      .o_mem_cs       (o_mem_cs),
      .o_mem_we       (o_mem_we),
      .o_mem_ref      (o_mem_ref),
      .o_mem_addr     (o_mem_addr),
      .o_pend_cnt     (o_pend_cnt),
      .o_ref_overrun  (o_ref_overrun)
   );

   always #5 clk = ~clk;

   // kind: 0 grant, 1 access cycle, 2 refresh cycle
   typedef struct packed {
      logic [1:0]    kind;
      logic          we;
      logic [AW-1:0] addr;
      logic          done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [1:0] k;
      if (!rst) begin
         chk("mutex", 32'($countones({o_req_ready, o_mem_cs, o_mem_ref}) > 1), 0);
         chk("we_without_cs", 32'(o_mem_we & ~o_mem_cs), 0);
         if (o_req_ready || o_mem_cs || o_mem_ref) begin
            k = o_req_ready ? 2'd0 : (o_mem_cs ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
               chk("unexpected_op", 32'(k), 32'd3);
            end else begin
               e = exp_q.pop_front();
               chk("op_kind", 32'(k), 32'(e.kind));
               chk("req_done", 32'(o_req_done), 32'(e.done));
               if (e.kind != 2'd0) begin
                  chk("mem_addr", 32'(o_mem_addr), 32'(e.addr));
                  chk("mem_we", 32'(o_mem_we), 32'(e.we));
               end
            end
         end
      end
   end

   task automatic push_acc(input logic w, input logic [AW-1:0] a);
      exp_q.push_back('{kind: 2'd0, we: 1'b0, addr: '0, done: 1'b0});
      exp_q.push_back('{kind: 2'd1, we: w, addr: a, done: 1'b0});
      exp_q.push_back('{kind: 2'd1, we: w, addr: a, done: 1'b1});
   endtask

   task automatic push_ref(input int row);
      for (int i = 0; i < 3; i++)
         exp_q.push_back('{kind: 2'd2, we: 1'b0, addr: AW'(row), done: 1'b0});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_grant();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   task automatic do_acc(input logic w, input logic [AW-1:0] a);
      push_acc(w, a);
      valid = 1'b1;
      we    = w;
      addr  = a;
      wait_grant();
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(o_req_ready), 0);
      chk({tag, "_cs"}, 32'(o_mem_cs), 0);
      chk({tag, "_ref"}, 32'(o_mem_ref), 0);
      chk({tag, "_we"}, 32'(o_mem_we), 0);
      chk({tag, "_addr"}, 32'(o_mem_addr), 0);
      chk({tag, "_pend"}, 32'(o_pend_cnt), 0);
      chk({tag, "_ovr"}, 32'(o_ref_overrun), 0);
   endtask

   initial begin
      // 1: reset, then quiet
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(3);
      check_all_zero("reset");
      en = 1'b1;

      // 2: write 0x1A5
      do_acc(1'b1, 9'h1A5);
      wait_cycles(4);
      chk("addr_hold", 32'(o_mem_addr), 32'h1A5);
      chk("idle_we", 32'(o_mem_we), 0);

      // 3: single refresh, then walk all rows and wrap
      push_ref(0);
      pulse_tick();
      @(negedge clk);
      chk("pend_after_tick", 32'(o_pend_cnt), 1);
      wait_cycles(5);
      chk("pend_after_ref", 32'(o_pend_cnt), 0);
      for (int r = 1; r <= 64; r++) begin
         push_ref(r % 64);
         pulse_tick();
         wait_cycles(5);
      end
      chk("q_empty_t3", 32'(exp_q.size()), 0);

      // 4: held request with four ticks; urgent refresh cuts in
      push_acc(1'b0, 9'h0F0);
      push_acc(1'b0, 9'h0F0);
      push_ref(1);
      push_acc(1'b0, 9'h0F0);
      push_ref(2);
      push_ref(3);
      push_ref(4);
      valid = 1'b1;
      we    = 1'b0;
      addr  = 9'h0F0;
      tick  = 1'b1;
      wait_cycles(4);
      tick = 1'b0;
      @(negedge clk);
      chk("pend_full", 32'(o_pend_cnt), 4);
      wait_grant();
      @(posedge clk);
      #1 valid = 1'b0;
      wait_cycles(20);
      chk("pend_drained", 32'(o_pend_cnt), 0);
      chk("q_empty_t4", 32'(exp_q.size()), 0);

      // 5: saturation while disabled, then coincident tick/completion
      en   = 1'b0;
      tick = 1'b1;
      wait_cycles(5);
      tick = 1'b0;
      wait_cycles(2);
      chk("pend_sat", 32'(o_pend_cnt), 4);
      chk("overrun_set", 32'(o_ref_overrun), 1);
      for (int r = 5; r <= 9; r++) push_ref(r);
      en = 1'b1;
      wait_cycles(3);
      tick = 1'b1;
      @(negedge clk);
      chk("ref_last_cycle", 32'(o_mem_ref), 1);
      chk("pend_before_coinc", 32'(o_pend_cnt), 4);
      @(posedge clk);
      #1 tick = 1'b0;
      @(negedge clk);
      chk("pend_coinc", 32'(o_pend_cnt), 4);
      wait_cycles(25);
      chk("pend_after_drain", 32'(o_pend_cnt), 0);
      chk("overrun_sticky", 32'(o_ref_overrun), 1);
      chk("q_empty_t5", 32'(exp_q.size()), 0);

      // 6a: reset in the middle of an access
      exp_q.push_back('{kind: 2'd0, we: 1'b0, addr: '0, done: 1'b0});
      valid = 1'b1;
      we    = 1'b1;
      addr  = 9'h0AA;
      wait_grant();
      @(posedge clk);
      #1 valid = 1'b0;
      chk("mid_acc_cs", 32'(o_mem_cs), 1);
      chk("q_empty_t6a", 32'(exp_q.size()), 0);
      rst = 1'b1;
      #1;
      check_all_zero("rst_acc");
      exp_q.delete();
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(1);
      do_acc(1'b1, 9'h055);
      wait_cycles(4);
      chk("post_rst_addr", 32'(o_mem_addr), 32'h055);

      // 6b: reset in the middle of a refresh
      pulse_tick();
      wait_cycles(1);
      chk("mid_ref", 32'(o_mem_ref), 1);
      chk("q_empty_t6b", 32'(exp_q.size()), 0);
      rst = 1'b1;
      #1;
      check_all_zero("rst_ref");
      exp_q.delete();
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(1);
      do_acc(1'b0, 9'h1FF);
      wait_cycles(4);
      chk("post_rst2_addr", 32'(o_mem_addr), 32'h1FF);
      chk("q_empty_end", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
